// File: rtl/sdram_tgen_pkg.sv
// Shared definitions for the SDRAM traffic generator: FSM states, pattern modes
// and the data-pattern function used by both the write generator and the read checker.
package sdram_tgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } tgen_state_e;

  localparam logic [1:0] PM_ADDR  = 2'd0;
  localparam logic [1:0] PM_NADDR = 2'd1;
  localparam logic [1:0] PM_CHECK = 2'd2;
  localparam logic [1:0] PM_SEED  = 2'd3;

  // Computed at a fixed wide width; callers truncate to their data width.
  localparam int PAT_W = 64;

  function automatic logic [PAT_W-1:0] pattern(input logic [1:0]       mode,
                                               input logic [PAT_W-1:0] a,
                                               input logic [7:0]       seed);
    case (mode)
      PM_ADDR:  pattern = a;
      PM_NADDR: pattern = ~a;
      PM_CHECK: pattern = a[0] ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
      default:  pattern = a ^ {8{seed}};
    endcase
  endfunction

endpackage

// File: rtl/sdram_tgen_checker.sv
// Read-back checker: regenerates the expected word for each return, counts mismatches
// (saturating). With SDRAM_TGEN_ERRLOG_EN it also captures the first failing address/data.
module sdram_tgen_checker
  import sdram_tgen_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int NUM_WORDS = 1024,
  parameter int BASE_ADDR = 0,
  parameter int ERR_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_mode,
  input  logic [7:0]        i_seed,
  output logic [ERR_W-1:0]  o_err_cnt
`ifdef SDRAM_TGEN_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic [DATA_W-1:0] o_first_err_data
`endif
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [IDX_W-1:0]  r_chk_idx;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] w_exp_addr;
  logic [DATA_W-1:0] w_exp_data;
  logic              w_mis;

  // Returns arrive in issue order, so a simple return counter names the address.
  assign w_exp_addr = BASE + ADDR_W'(r_chk_idx);
  assign w_exp_data = DATA_W'(pattern(i_mode, PAT_W'(w_exp_addr), i_seed));
  assign w_mis      = i_vld && (i_data != w_exp_data);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_chk_idx <= '0;
    end else if (i_vld) begin
      r_chk_idx <= r_chk_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_err_cnt <= '0;
    end else if (w_mis && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_err_cnt = r_err_cnt;

`ifdef SDRAM_TGEN_ERRLOG_EN
  logic              r_err_seen;
  logic [ADDR_W-1:0] r_first_addr;
  logic [DATA_W-1:0] r_first_data;

  // Separate flag so capture stays frozen even if the counter saturates or wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_err_seen   <= 1'b0;
      r_first_addr <= '0;
      r_first_data <= '0;
    end else if (w_mis && !r_err_seen) begin
      r_err_seen   <= 1'b1;
      r_first_addr <= w_exp_addr;
      r_first_data <= i_data;
    end
  end

  assign o_first_err_addr = r_first_addr;
  assign o_first_err_data = r_first_data;
`endif

endmodule

// File: rtl/sdram_traffic_gen.sv
// SDRAM exerciser: on a button edge writes NUM_WORDS pattern words from BASE_ADDR, reads
// them back in order and reports pass/fail. Optional SDRAM_TGEN_ERRLOG_EN adds first-error ports.
module sdram_traffic_gen
  import sdram_tgen_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int NUM_WORDS = 1024,
  parameter int BASE_ADDR = 0,
  parameter int MAX_OUTST = 4,
  parameter int ERR_W     = 16
) (
  input  logic              CLOCK_100,
  input  logic              rst_n,
  input  logic              button,
  input  logic [1:0]        pat_mode,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [7:0]        led
`ifdef SDRAM_TGEN_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
`endif
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        MAX_O    = 4'(MAX_OUTST);

  tgen_state_e r_state, w_nxt;

  logic              r_btn_q;
  logic [1:0]        r_mode;
  logic [7:0]        r_seed;
  logic [IDX_W-1:0]  r_wr_idx;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [3:0]        r_outst;
  logic              r_drain_last;
  logic              r_done;
  logic              r_pass;

  logic              w_start;
  logic              w_go;
  logic              w_wr_hs;
  logic              w_rd_hs;
  logic              w_ret;
  logic              w_rd_room;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [ERR_W-1:0]  w_err_cnt;

  assign w_start   = button && !r_btn_q;
  assign w_go      = w_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_rd_room = (r_outst < MAX_O);
  assign w_wr_hs   = (r_state == ST_WRITE) && cmd_ready;
  assign w_rd_hs   = (r_state == ST_READ) && w_rd_room && cmd_ready;
  // Returns only count while a read is actually pending; stray ones are dropped.
  assign w_ret     = rd_valid && (r_outst != '0) &&
                     ((r_state == ST_READ) || (r_state == ST_DRAIN));

  assign w_wr_addr = BASE + ADDR_W'(r_wr_idx);
  assign w_rd_addr = BASE + ADDR_W'(r_rd_idx);
  assign w_wr_data = DATA_W'(pattern(r_mode, PAT_W'(w_wr_addr), r_seed));

  always_ff @(posedge CLOCK_100) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_go) w_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = w_wr_addr;
        cmd_wdata = w_wr_data;
        if (cmd_ready && (r_wr_idx == LAST_IDX)) w_nxt = ST_READ;
      end
      ST_READ: begin
        cmd_valid = w_rd_room;
        cmd_addr  = w_rd_addr;
        if (w_rd_hs && (r_rd_idx == LAST_IDX)) w_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain_last) w_nxt = ST_DONE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_100) begin
    if (!rst_n) begin
      r_btn_q <= 1'b0;
      r_mode  <= PM_ADDR;
    end else begin
      r_btn_q <= button;
      if (w_go) r_mode <= pat_mode;
    end
  end

  always_ff @(posedge CLOCK_100) begin
    if (!rst_n || w_go) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
    end else begin
      if (w_wr_hs) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_rd_hs) r_rd_idx <= r_rd_idx + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_100) begin
    if (!rst_n || w_go) begin
      r_outst <= '0;
    end else begin
      case ({w_rd_hs, w_ret})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // One extra cycle after the last return lets the registered compare land in err_cnt.
  always_ff @(posedge CLOCK_100) begin
    if (!rst_n) r_drain_last <= 1'b0;
    else        r_drain_last <= (r_state == ST_DRAIN) && (r_outst == '0) && !r_drain_last;
  end

  always_ff @(posedge CLOCK_100) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_seed <= '0;
    end else if (w_go) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if ((r_state == ST_DRAIN) && r_drain_last) begin
      r_done <= 1'b1;
      r_pass <= (w_err_cnt == '0);
      r_seed <= r_seed + 1'b1;
    end
  end

  sdram_tgen_checker #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_WORDS(NUM_WORDS),
    .BASE_ADDR(BASE_ADDR),
    .ERR_W    (ERR_W)
  ) u_checker (
    .i_clk           (CLOCK_100),
    .i_rst_n         (rst_n),
    .i_clr           (w_go),
    .i_vld           (w_ret),
    .i_data          (rd_data),
    .i_mode          (r_mode),
    .i_seed          (r_seed),
    .o_err_cnt       (w_err_cnt)
`ifdef SDRAM_TGEN_ERRLOG_EN
    ,
    .o_first_err_addr(first_err_addr),
    .o_first_err_data(first_err_data)
`endif
  );

  assign busy    = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = w_err_cnt;
  assign led     = {r_pass, r_done, busy, (w_err_cnt != '0), r_seed[3:0]};

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Bench for sdram_traffic_gen: memory/controller model with random ready and in-order
// latency, fault injection on returns, and a pass-level reference model.
module tb_sdram_traffic_gen;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int NW     = 16;
  localparam int BASE   = 0;
  localparam int MAXO   = 4;
  localparam int ERR_W  = 3;
  localparam logic [15:0] FLIP = 16'h0010;

  logic              CLOCK_100 = 1'b0;
  logic              rst_n = 1'b0;
  logic              button = 1'b0;
  logic [1:0]        pat_mode = 2'd0;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rd_valid = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              busy, done, pass;
  logic [ERR_W-1:0]  err_cnt;
  logic [7:0]        led;
`ifdef SDRAM_TGEN_ERRLOG_EN
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;
`endif

  sdram_traffic_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NW), .BASE_ADDR(BASE),
    .MAX_OUTST(MAXO), .ERR_W(ERR_W)
  ) dut (
    .CLOCK_100(CLOCK_100), .rst_n(rst_n), .button(button), .pat_mode(pat_mode),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt), .led(led)
`ifdef SDRAM_TGEN_ERRLOG_EN
    , .first_err_addr(first_err_addr), .first_err_data(first_err_data)
`endif
  );

  always #5 CLOCK_100 = ~CLOCK_100;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int mode, input logic [23:0] a, input logic [7:0] s);
    case (mode)
      0:       return a[15:0];
      1:       return ~a[15:0];
      2:       return a[0] ? 16'hAAAA : 16'h5555;
      default: return a[15:0] ^ {s, s};
    endcase
  endfunction

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          flip;
    int          idx;
    int          gen;
  } rent_t;

  rent_t       q[$];
  rent_t       e;
  logic [15:0] mem [int];
  logic [15:0] wlog [NW];

  int          cyc = 0, gen = 0, last_due = 0;
  int          cur_mode = 0, ready_pct = 100, lat = 3, stall_at = -1, stall_left = 0;
  bit          stall_done = 0;
  logic [15:0] inj = '0;
  int          wr_k = 0, rd_k = 0, ret_k = 0, n_out = 0, exp_err = 0, first_idx = -1;
  logic [15:0] first_data = '0;
  logic [7:0]  exp_seed = '0;
  bit          prev_hold = 0;
  logic [63:0] prev_bus = '0;
  bit          hs;
  logic [23:0] ea;

  // Controller/memory model and per-cycle checker; decisions take effect at the next posedge.
  always @(negedge CLOCK_100) begin
    cyc++;
    if (!rst_n) begin
      gen++;
      n_out = 0;
    end
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      rd_valid = 1'b1;
      rd_data  = e.flip ? (e.data ^ FLIP) : e.data;
      if (e.gen == gen && rst_n) begin
        n_out--;
        ret_k++;
        if (e.flip) begin
          exp_err++;
          if (first_idx < 0) begin
            first_idx  = e.idx;
            first_data = e.data ^ FLIP;
          end
        end
      end
    end else begin
      rd_valid = 1'b0;
      rd_data  = 16'($urandom);
    end
    if (stall_at >= 0 && !stall_done && wr_k == stall_at && rst_n) begin
      stall_done = 1;
      stall_left = 7;
    end
    if (stall_left > 0) begin
      cmd_ready  = 1'b0;
      stall_left--;
    end else begin
      cmd_ready = ($urandom_range(0, 99) < ready_pct);
    end
    #1;
    if (rst_n && prev_hold)
      chk("hold_stable", {cmd_valid, cmd_we, 6'd0, cmd_addr, 16'd0, cmd_wdata}, prev_bus);
    hs = rst_n && cmd_valid && cmd_ready;
    if (hs && cmd_we) begin
      ea = 24'(BASE + wr_k);
      chk("wr_in_range", (wr_k < NW), 1);
      chk("wr_addr", cmd_addr, ea);
      chk("wr_data", cmd_wdata, pat(cur_mode, ea, exp_seed));
      mem[int'(cmd_addr)] = cmd_wdata;
      if (wr_k < NW) wlog[wr_k] = cmd_wdata;
      wr_k++;
    end else if (hs) begin
      ea = 24'(BASE + rd_k);
      chk("rd_after_wr", wr_k, NW);
      chk("rd_in_range", (rd_k < NW), 1);
      chk("rd_addr", cmd_addr, ea);
      e.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      e.data = mem.exists(int'(cmd_addr)) ? mem[int'(cmd_addr)] : 16'h0;
      e.flip = (rd_k < NW) ? inj[rd_k] : 1'b0;
      e.idx  = rd_k;
      e.gen  = gen;
      last_due = e.due;
      q.push_back(e);
      rd_k++;
      n_out++;
    end
    if (rst_n && n_out > 0) chk("outst_le_max", (n_out <= MAXO), 1);
    prev_hold = rst_n && cmd_valid && !cmd_ready;
    prev_bus  = {cmd_valid, cmd_we, 6'd0, cmd_addr, 16'd0, cmd_wdata};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_100);
    #2;
  endtask

  task automatic check_reset_state();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_led", led, 0);
`ifdef SDRAM_TGEN_ERRLOG_EN
    chk("rst_first_err_addr", first_err_addr, 0);
`endif
  endtask

  task automatic do_reset(input int n);
    @(posedge CLOCK_100); #2;
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
    exp_seed = '0;
    check_reset_state();
  endtask

  task automatic start_pass(input int mode, input int rdy, input int lt,
                            input logic [15:0] mask, input int stall);
    int w;
    w = 0;
    while (q.size() != 0 && w < 300) begin tick(1); w++; end
    chk("ctl_idle_before_start", q.size(), 0);
    tick(2);
    cur_mode = mode; ready_pct = rdy; lat = lt; inj = mask;
    stall_at = stall; stall_done = 0; stall_left = 0;
    wr_k = 0; rd_k = 0; ret_k = 0; n_out = 0; exp_err = 0; first_idx = -1; first_data = '0;
    pat_mode = mode[1:0];
    button = 1'b1;
    tick(1);
    button = 1'b0;
    pat_mode = 2'($urandom);
    tick(1);
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err_cnt, 0);
  endtask

  task automatic finish_pass();
    int w;
    int es;
    bit ep;
    w = 0;
    while (!done && w < 4000) begin tick(1); w++; end
    chk("done_reached", done, 1);
    chk("end_busy", busy, 0);
    exp_seed = exp_seed + 8'd1;
    chk("writes_total", wr_k, NW);
    chk("reads_total", rd_k, NW);
    chk("returns_total", ret_k, NW);
    chk("outst_zero", n_out, 0);
    es = (exp_err > 7) ? 7 : exp_err;
    ep = (exp_err == 0);
    chk("err_cnt", err_cnt, es);
    chk("pass", pass, ep);
    chk("led", led, {ep, 1'b1, 1'b0, (es != 0), exp_seed[3:0]});
`ifdef SDRAM_TGEN_ERRLOG_EN
    chk("first_err_addr", first_err_addr, (first_idx >= 0) ? 24'(BASE + first_idx) : 24'd0);
    chk("first_err_data", first_err_data, (first_idx >= 0) ? first_data : 16'd0);
`endif
  endtask

  initial begin
    int w;
    do_reset(5);

    // Mode 0, full-speed controller: data equals address.
    start_pass(0, 100, 3, 16'h0000, -1);
    finish_pass();
    chk("lit_m0_w3", wlog[3], 16'h0003);
    chk("lit_m0_w15", wlog[15], 16'h000F);
    chk("lit_pass_led", led, 8'hC1);

    // Mode 1 with a 7-cycle ready stall mid-write and an ignored start while busy.
    start_pass(1, 70, 9, 16'h0000, 6);
    tick(10);
    button = 1'b1; tick(1); button = 1'b0;
    finish_pass();
    chk("lit_m1_w0", wlog[0], 16'hFFFF);

    // Mode 2, latency 9, bit flip on word 5.
    start_pass(2, 60, 9, 16'h0020, -1);
    finish_pass();
    chk("lit_flip_err", err_cnt, 1);
    chk("lit_flip_pass", pass, 0);
`ifdef SDRAM_TGEN_ERRLOG_EN
    chk("lit_first_err_addr", first_err_addr, 24'd5);
`endif

    // Two mode-3 passes from reset: seed 0 then seed 1.
    do_reset(3);
    start_pass(3, 90, 5, 16'h0000, -1);
    finish_pass();
    start_pass(3, 90, 5, 16'h0000, -1);
    finish_pass();
    chk("lit_m3_w0", wlog[0], 16'h0101);
    chk("lit_m3_w7", wlog[7], 16'h0106);
    chk("lit_led_seed", led[3:0], 4'd2);

    // Every word corrupted: counter saturates.
    start_pass(0, 80, 4, 16'hFFFF, -1);
    finish_pass();
    chk("lit_sat", err_cnt, 3'd7);

    // Reset during READ, then a clean pass while stale returns drain.
    start_pass(0, 80, 9, 16'h0000, -1);
    w = 0;
    while (rd_k < 6 && w < 500) begin tick(1); w++; end
    chk("reached_read", (rd_k >= 6), 1);
    do_reset(2);
    start_pass(3, 75, 9, 16'h0000, -1);
    finish_pass();

    // Randomized passes.
    for (int p = 0; p < 5; p++) begin
      start_pass($urandom_range(0, 3), $urandom_range(30, 100), $urandom_range(1, 12),
                 16'($urandom) & 16'($urandom) & 16'($urandom),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : -1);
      finish_pass();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
